qracc_csr_slave: RTL and testbench
==================================

// Module: qracc_csr_slave
// PURPOSE
// - Slave (responder) end of qracc_ctrl_interface; master is the host/CSR bus bridge.
// - Decodes word-addressed register accesses into a shadow copy of qracc_config_t.
// - Commits shadow to the live cfg_o atomically, only while the accelerator is idle.
// - cfg_o feeds the QRAcc controller, feature loader and output scaler.
// PARAMETERS
// - BASE_ADDR  32'h0000_0000  block base; hit when addr[31:8]==BASE_ADDR[31:8]
// - IN_BITS    inputBits      reset value of n_input_bits_cfg
// - OUT_BITS   outputBits     reset value of n_output_bits_cfg
// PORTS
// - clk         in   1    clock
// - rst         in   1    asynchronous reset, active-high
// - ctrl_data   in   32   write data
// - ctrl_addr   in   32   byte address, word aligned (addr[1:0] ignored)
// - ctrl_wen    in   1    1=write, 0=read
// - ctrl_valid  in   1    request valid; held by master until ctrl_ready
// - ctrl_ready  out  1    one-cycle response strobe; read_data valid with it
// - ctrl_rdata  out  32   read data
// - busy_i      in   1    accelerator mid-layer; blocks commit
// - cfg_o       out  $bits(qracc_config_t)  live config
// - cfg_upd_o   out  1    one-cycle pulse when cfg_o changes
// BEHAVIOUR
// - Reset: ctrl_ready=0, ctrl_rdata=0, cfg_upd_o=0, pending=0, err=0.
//   Shadow and live: all fields 0 except filter_size_x/y=1, stride_x/y=1,
//   n_input_bits=IN_BITS, n_output_bits=OUT_BITS.
// - FSM IDLE/RESP. IDLE & ctrl_valid: capture request, perform write/read, go RESP.
//   RESP: ctrl_ready=1 for exactly one cycle, ctrl_valid ignored, return to IDLE.
// - Latency: valid sampled at edge N -> ready high during cycle N+1.
//   Max throughput: one access per 2 cycles.
// - Register map (offset: fields, LSB first):
//   00 CTRL: [0] commit (W1, reads 0), [1] pending (RO), [2] err (W1C), [3] chk_fail (RO)
//   04 BITS: [3:0] n_in, [7:4] n_out, [8] binary, [9] unsigned_acts, [12:10] adc_shift
//   08 GEOM: [3:0] fy, [7:4] fx, [11:8] stride_x, [15:12] stride_y
//   0C in_fmap_size; 10 out_fmap_size; 14 in_dimx; 18 in_dimy; 1C out_dimx; 20 out_dimy
//   24 CH: [9:0] in_ch, [25:16] out_ch
//   28 OFS: [9:0] offset_x, [25:16] offset_y
//   Unused bits: write-ignored, read 0.
// - Reads of 04..28 return the shadow copy.
// - Unmapped or out-of-base access: write dropped, read returns 0, err set.
//   ctrl_ready is still given.
// - Commit request (CTRL write, bit0=1):
//   - busy_i=0 at capture edge: live<=shadow at that edge; cfg_upd_o high in RESP cycle.
//   - busy_i=1: pending<=1.
//   - While pending, first cycle with busy_i=0: live<=shadow, pending<=0,
//     cfg_upd_o pulses next cycle.
//   - Commit while pending: no-op.
// - Shadow writes (04..28) while pending: dropped, err set; keeps the snapshot consistent.
// - Same CTRL write with bit0=1 and bit2=1: err cleared and commit processed.
// - Reset mid-transaction: FSM->IDLE, no ready issued; master must reissue.
// CONFIGURATION
// - QRACC_CSR_PARAM_CHECK_EN defined: at commit, shadow is validated:
//   stride_x/y!=0, fx/fy!=0, in_ch!=0, n_in in 1..8.
//   Fail: no commit, no pending, chk_fail<=1, err<=1.
//   chk_fail clears on the next successful commit.
// - Undefined: no validation; CTRL[3] reads 0.
// TESTING
// - Reset -> cfg_o.stride_x=1, n_input_bits=IN_BITS; read 0x08 returns 32'h0000_1111.
// - Write 0x0C=32'd4096, busy_i=0, commit -> ready 1 cycle after valid.
//   cfg_o.input_fmap_size=4096; single cfg_upd_o pulse.
// - busy_i=1, commit -> CTRL reads 0x2; write 0x24 dropped, err=1.
//   Drop busy_i -> cfg_o updates, cfg_upd_o pulses, pending=0.
// - Read 0x100 (unmapped) -> ready, rdata=0, CTRL[2]=1; write CTRL=0x4 -> CTRL[2]=0.
// - PARAM_CHECK_EN: set GEOM=0x0011 (strides 0), commit -> cfg_o unchanged,
//   CTRL reads 0xC; fix strides, commit -> CTRL[3]=0.
// - Assert rst while in RESP -> ctrl_ready=0 immediately; cfg_o at reset values.

Source files
------------

// File: rtl/qracc_csr_slave.sv
// CSR responder for the QRAcc control interface: shadow config registers committed to cfg_o
// only while the accelerator is idle. Optional commit-time validation: QRACC_CSR_PARAM_CHECK_EN.
module qracc_csr_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned IN_BITS   = 8,
  parameter int unsigned OUT_BITS  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  ctrl_data,
  input  logic [31:0]  ctrl_addr,
  input  logic         ctrl_wen,
  input  logic         ctrl_valid,
  output logic         ctrl_ready,
  output logic [31:0]  ctrl_rdata,
  input  logic         busy_i,
  // cfg_o LSB first: n_in[3:0] n_out[7:4] binary[8] unsigned_acts[9] adc_shift[12:10]
  // fy[16:13] fx[20:17] stride_x[24:21] stride_y[28:25] in_fmap_size[60:29]
  // out_fmap_size[92:61] in_dimx[124:93] in_dimy[156:125] out_dimx[188:157]
  // out_dimy[220:189] in_ch[230:221] out_ch[240:231] offset_x[250:241] offset_y[260:251]
  output logic [260:0] cfg_o,
  output logic         cfg_upd_o
);

  localparam logic [3:0]   InBits  = 4'(IN_BITS);
  localparam logic [3:0]   OutBits = 4'(OUT_BITS);
  localparam logic [260:0] CfgRst  = {232'd0, 4'd1, 4'd1, 4'd1, 4'd1, 5'd0, OutBits, InBits};

  typedef enum logic {StIdle, StResp} state_e;

  state_e         state_q, state_d;
  logic [260:0]   shadow_q, shadow_d;
  logic [260:0]   live_q, live_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           pending_q, pending_d;
  logic           err_q, err_d;
  logic           chk_q, chk_d;
  logic           upd_q, upd_d;

  logic [5:0]     word;
  logic           hit;
  logic           mapped;
  logic           chk_ok;
  logic [31:0]    read_mux;
  logic           commit_req;
  logic           set_err;
  logic           clr_err;
  logic           unused_addr;

  assign word        = ctrl_addr[7:2];
  assign hit         = (ctrl_addr[31:8] == BASE_ADDR[31:8]);
  assign mapped      = hit && (word <= 6'd10);
  assign unused_addr = ^ctrl_addr[1:0];

`ifdef QRACC_CSR_PARAM_CHECK_EN
  assign chk_ok = (shadow_q[24:21] != 4'd0) && (shadow_q[28:25] != 4'd0) &&
                  (shadow_q[16:13] != 4'd0) && (shadow_q[20:17] != 4'd0) &&
                  (shadow_q[230:221] != 10'd0) &&
                  (shadow_q[3:0] != 4'd0) && (shadow_q[3:0] <= 4'd8);
`else
  assign chk_ok = 1'b1;
`endif

  always_comb begin
    read_mux = '0;
    case (word)
      6'd0:    read_mux = {28'd0, chk_q, err_q, pending_q, 1'b0};
      6'd1:    read_mux = {19'd0, shadow_q[12:0]};
      6'd2:    read_mux = {16'd0, shadow_q[28:13]};
      6'd3:    read_mux = shadow_q[60:29];
      6'd4:    read_mux = shadow_q[92:61];
      6'd5:    read_mux = shadow_q[124:93];
      6'd6:    read_mux = shadow_q[156:125];
      6'd7:    read_mux = shadow_q[188:157];
      6'd8:    read_mux = shadow_q[220:189];
      6'd9:    read_mux = {6'd0, shadow_q[240:231], 6'd0, shadow_q[230:221]};
      6'd10:   read_mux = {6'd0, shadow_q[260:251], 6'd0, shadow_q[250:241]};
      default: read_mux = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    live_d     = live_q;
    rdata_d    = rdata_q;
    pending_d  = pending_q;
    err_d      = err_q;
    chk_d      = chk_q;
    upd_d      = 1'b0;
    commit_req = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    ctrl_ready = 1'b0;

    // A deferred commit fires on the first idle cycle; shadow is frozen meanwhile.
    if (pending_q && !busy_i) begin
      live_d    = shadow_q;
      pending_d = 1'b0;
      upd_d     = 1'b1;
      chk_d     = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (ctrl_valid) begin
          state_d = StResp;
          rdata_d = '0;
          if (!mapped) begin
            set_err = 1'b1;
          end else if (!ctrl_wen) begin
            rdata_d = read_mux;
          end else if (word == 6'd0) begin
            clr_err    = ctrl_data[2];
            commit_req = ctrl_data[0] && !pending_q;
          end else if (pending_q) begin
            set_err = 1'b1;
          end else begin
            case (word)
              6'd1:    shadow_d[12:0]    = ctrl_data[12:0];
              6'd2:    shadow_d[28:13]   = ctrl_data[15:0];
              6'd3:    shadow_d[60:29]   = ctrl_data;
              6'd4:    shadow_d[92:61]   = ctrl_data;
              6'd5:    shadow_d[124:93]  = ctrl_data;
              6'd6:    shadow_d[156:125] = ctrl_data;
              6'd7:    shadow_d[188:157] = ctrl_data;
              6'd8:    shadow_d[220:189] = ctrl_data;
              6'd9: begin
                shadow_d[230:221] = ctrl_data[9:0];
                shadow_d[240:231] = ctrl_data[25:16];
              end
              6'd10: begin
                shadow_d[250:241] = ctrl_data[9:0];
                shadow_d[260:251] = ctrl_data[25:16];
              end
              default: ;
            endcase
          end
        end
      end
      StResp: begin
        ctrl_ready = 1'b1;
        state_d    = StIdle;
      end
    endcase

    if (commit_req) begin
      if (!chk_ok) begin
        chk_d   = 1'b1;
        set_err = 1'b1;
      end else if (busy_i) begin
        pending_d = 1'b1;
      end else begin
        live_d = shadow_q;
        upd_d  = 1'b1;
        chk_d  = 1'b0;
      end
    end

    // Setting wins so a failed commit in a W1C write still reports its error.
    if (clr_err) err_d = 1'b0;
    if (set_err) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= CfgRst;
      live_q    <= CfgRst;
      rdata_q   <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      chk_q     <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      live_q    <= live_d;
      rdata_q   <= rdata_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      chk_q     <= chk_d;
      upd_q     <= upd_d;
    end
  end

  assign ctrl_rdata = rdata_q;
  assign cfg_o      = live_q;
  assign cfg_upd_o  = upd_q;

endmodule

// File: tb/tb_qracc_csr_slave.sv
// Self-checking bench for qracc_csr_slave: directed scenarios then randomized accesses
// checked against a register-image reference model.
module tb_qracc_csr_slave;

  localparam logic [31:0] B       = 32'h4000_0000;
  localparam int unsigned TB_IN   = 6;
  localparam int unsigned TB_OUT  = 5;

  logic         clk;
  logic         rst;
  logic [31:0]  ctrl_data;
  logic [31:0]  ctrl_addr;
  logic         ctrl_wen;
  logic         ctrl_valid;
  logic         ctrl_ready;
  logic [31:0]  ctrl_rdata;
  logic         busy_i;
  logic [260:0] cfg_o;
  logic         cfg_upd_o;

  qracc_csr_slave #(
    .BASE_ADDR (B),
    .IN_BITS   (TB_IN),
    .OUT_BITS  (TB_OUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_data  (ctrl_data),
    .ctrl_addr  (ctrl_addr),
    .ctrl_wen   (ctrl_wen),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .ctrl_rdata (ctrl_rdata),
    .busy_i     (busy_i),
    .cfg_o      (cfg_o),
    .cfg_upd_o  (cfg_upd_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register images (index = word offset) for shadow and live config.
  logic [31:0] sh [0:10];
  logic [31:0] lv [0:10];
  logic        m_pend, m_err, m_chk, m_resp, exp_upd, exp_is_rd;
  logic [31:0] exp_rdata, last_rd;

  task automatic check_eq(input string tag, input logic [260:0] got, input logic [260:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_mask(input int w);
    case (w)
      1:       return 32'h0000_1FFF;
      2:       return 32'h0000_FFFF;
      9, 10:   return 32'h03FF_03FF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [260:0] exp_cfg();
    return {lv[10][25:16], lv[10][9:0], lv[9][25:16], lv[9][9:0], lv[8], lv[7], lv[6],
            lv[5], lv[4], lv[3], lv[2][15:0], lv[1][12:0]};
  endfunction

  function automatic logic params_ok();
`ifdef QRACC_CSR_PARAM_CHECK_EN
    return (sh[2][3:0] != 0) && (sh[2][7:4] != 0) && (sh[2][11:8] != 0) &&
           (sh[2][15:12] != 0) && (sh[9][9:0] != 0) && (sh[1][3:0] >= 1) && (sh[1][3:0] <= 8);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= 10; i++) sh[i] = 32'd0;
    sh[1] = (TB_OUT << 4) | TB_IN;
    sh[2] = 32'h0000_1111;
    lv = sh;
    m_pend = 0; m_err = 0; m_chk = 0; m_resp = 0; exp_upd = 0; exp_is_rd = 0;
    exp_rdata = 0;
  endtask

  // Applies the effect of the coming clock edge given the inputs now being driven.
  task automatic model_edge();
    logic old_pend;
    logic set_err, clr_err;
    int   w;
    old_pend = m_pend;
    set_err  = 0;
    clr_err  = 0;
    exp_upd  = 0;
    if (m_resp) begin
      m_resp = 0;
    end else if (ctrl_valid) begin
      m_resp    = 1;
      exp_is_rd = !ctrl_wen;
      exp_rdata = 0;
      w = int'(ctrl_addr[7:2]);
      if (ctrl_addr[31:8] != B[31:8] || w > 10) begin
        set_err = 1;
      end else if (!ctrl_wen) begin
        exp_rdata = (w == 0) ? {28'd0, m_chk, m_err, m_pend, 1'b0} : sh[w];
      end else if (w == 0) begin
        clr_err = ctrl_data[2];
        if (ctrl_data[0] && !old_pend) begin
          if (!params_ok()) begin
            m_chk = 1;
            set_err = 1;
          end else if (busy_i) begin
            m_pend = 1;
          end else begin
            lv = sh;
            exp_upd = 1;
            m_chk = 0;
          end
        end
      end else if (old_pend) begin
        set_err = 1;
      end else begin
        sh[w] = ctrl_data & reg_mask(w);
      end
    end
    if (old_pend && !busy_i) begin
      lv = sh;
      m_pend = 0;
      exp_upd = 1;
      m_chk = 0;
    end
    if (clr_err) m_err = 0;
    if (set_err) m_err = 1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("ready", ctrl_ready, m_resp);
    check_eq("cfg", cfg_o, exp_cfg());
    check_eq("cfg_upd", cfg_upd_o, exp_upd);
    if (m_resp && exp_is_rd) check_eq("rdata", ctrl_rdata, exp_rdata);
  endtask

  // Master holds valid through the response cycle, as a real bridge would.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
    ctrl_wen   = w;
    ctrl_addr  = a;
    ctrl_data  = d;
    ctrl_valid = 1'b1;
    step();
    last_rd = ctrl_rdata;
    step();
    ctrl_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ctrl_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", ctrl_ready, 1'b0);
    check_eq("rst_rdata", ctrl_rdata, 32'd0);
    check_eq("rst_upd", cfg_upd_o, 1'b0);
    check_eq("rst_cfg", cfg_o, exp_cfg());
    @(negedge clk);
    rst = 1'b0;
  endtask

  int          sel;
  logic [31:0] ra, rd;

  initial begin
    #200000;
    $display("FAIL watchdog expired, run did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ctrl_data = 0; ctrl_addr = 0; ctrl_wen = 0; ctrl_valid = 0; busy_i = 0;
    apply_reset();
    check_eq("rst_stride_x", cfg_o[24:21], 4'd1);
    check_eq("rst_n_in", cfg_o[3:0], 4'(TB_IN));
    step();

    access(1'b0, B + 32'h08, 32'd0);
    check_eq("geom_rst_read", last_rd, 32'h0000_1111);

    access(1'b1, B + 32'h0C, 32'd4096);
    access(1'b1, B + 32'h00, 32'h1);
    check_eq("fmap_committed", cfg_o[60:29], 32'd4096);

    access(1'b1, B + 32'h10, 32'd777);
    busy_i = 1'b1;
    access(1'b1, B + 32'h00, 32'h1);
    access(1'b0, B + 32'h00, 32'd0);
    check_eq("ctrl_pending", last_rd, 32'h2);
    access(1'b1, B + 32'h24, 32'h0005_0003);
    access(1'b0, B + 32'h00, 32'd0);
    check_eq("ctrl_pend_err", last_rd, 32'h6);
    repeat (3) step();
    check_eq("held_while_busy", cfg_o[92:61], 32'd0);
    busy_i = 1'b0;
    step();
    check_eq("deferred_upd", cfg_upd_o, 1'b1);
    check_eq("deferred_cfg", cfg_o[92:61], 32'd777);
    access(1'b0, B + 32'h00, 32'd0);
    check_eq("ctrl_after_commit", last_rd, 32'h4);

    access(1'b1, B + 32'h00, 32'h4);
    access(1'b0, B + 32'h100, 32'd0);
    check_eq("unmapped_rdata", last_rd, 32'd0);
    access(1'b0, B + 32'h00, 32'd0);
    check_eq("err_set", last_rd[2], 1'b1);
    access(1'b1, B + 32'h00, 32'h4);
    access(1'b0, B + 32'h00, 32'd0);
    check_eq("err_cleared", last_rd, 32'd0);
    access(1'b1, B + 32'h2C, 32'hFFFF_FFFF);
    access(1'b0, B + 32'h00, 32'd0);
    check_eq("inbase_unmapped_err", last_rd[2], 1'b1);

`ifdef QRACC_CSR_PARAM_CHECK_EN
    access(1'b1, B + 32'h08, 32'h0011);
    access(1'b1, B + 32'h00, 32'h5);
    access(1'b0, B + 32'h00, 32'd0);
    check_eq("chk_fail_ctrl", last_rd, 32'hC);
    check_eq("chk_fail_geom", cfg_o[28:13], 16'h1111);
    access(1'b1, B + 32'h08, 32'h1111);
    access(1'b1, B + 32'h00, 32'h5);
    access(1'b0, B + 32'h00, 32'd0);
    check_eq("chk_cleared", last_rd[3], 1'b0);
`endif

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) busy_i = ~busy_i;
      sel = int'($urandom_range(0, 15));
      rd  = $urandom();
      if (sel <= 10) begin
        ra = B + 32'(sel * 4);
      end else if (sel <= 12) begin
        ra = B;
        rd = 32'($urandom_range(0, 15));
      end else if (sel == 13) begin
        ra = B + 32'($urandom_range(11, 63) * 4);
      end else begin
        ra = 32'h8000_0000 | 32'($urandom_range(0, 255));
      end
      ra[1:0] = 2'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), ra, rd);
      if ($urandom_range(0, 1) == 1) step();
    end

    busy_i = 1'b0;
    access(1'b1, B + 32'h14, 32'hDEAD_BEEF);
    access(1'b1, B + 32'h00, 32'h5);
    ctrl_wen   = 1'b0;
    ctrl_addr  = B + 32'h14;
    ctrl_valid = 1'b1;
    step();
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("midresp_ready", ctrl_ready, 1'b0);
    check_eq("midresp_cfg", cfg_o, exp_cfg());
    check_eq("midresp_rdata", ctrl_rdata, 32'd0);
    ctrl_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    access(1'b0, B + 32'h08, 32'd0);
    check_eq("post_rst_geom", last_rd, 32'h0000_1111);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
